uno_card_pile: RTL and testbench
================================

# uno_card_pile

Parametrised card-pile manager for the UNO game datapath: it holds a draw pile and a discard pile of `CARD_W`-bit card codes, each up to `DEPTH` entries. It provides load/discard pushes, LFSR-driven Fisher–Yates shuffle and multi-card draw requests. When the draw pile runs dry mid-draw, it refills from the discard pile and reshuffles automatically. It sits between the game-control FSM and the per-player hand logic; card encoding is opaque to the block.

## Interface
- `CARD_W`, 6: card code width (2-bit colour + 4-bit value in the game).
- `DEPTH`, 108: capacity of each pile.
- `IDX_W`, 7: index width; `2**IDX_W >= DEPTH` required.
- `CNT_W`, 8: pile-count width; holds 0..`DEPTH`.
- `MAX_DRAW`, 4: largest legal draw count.
- `SEED`, 16'hACE1: XOR constant applied to the seed.

Ports:
- `i_clk` in 1: clock.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_put_valid` in 1: push `i_put_card`; accepted only when `o_ready`.
- `i_put_dst` in 1: push target; 0 = draw pile, 1 = discard pile.
- `i_put_card` in `CARD_W`: card to push.
- `i_shuffle` in 1: shuffle-request pulse; accepted only when `o_ready`.
- `i_draw_valid` in 1: draw request; accepted only when `o_ready`.
- `i_draw_cnt` in 3: cards to draw. Legal range 1..`MAX_DRAW`; 0 is treated as 1, values above `MAX_DRAW` are clamped to `MAX_DRAW`.
- `o_ready` out 1: block is in IDLE.
- `o_card_valid` out 1: one-cycle strobe, `o_card` is a drawn card.
- `o_card` out `CARD_W`: drawn card; holds its last value otherwise.
- `o_done` out 1: one-cycle pulse at the end of a shuffle or draw.
- `o_short` out 1: valid with `o_done`; draw ended with fewer cards than requested.
- `o_overflow` out 1: one-cycle pulse, push dropped because the target pile was full.
- `o_draw_cnt` out `CNT_W`: draw-pile occupancy.
- `o_disc_cnt` out `CNT_W`: discard-pile occupancy.

## Operation
- **Storage and tops.** Storage is two register arrays, `draw[DEPTH]` and `disc[DEPTH]`. Top of each pile = entry at index count-1.
- **Reset values.** State IDLE. Both counts 0. All array entries 0. `o_card` 0. All strobes 0. `o_ready` 1. LFSR = 16'h0001. Free counter 0.
- **Free counter.** 16-bit, increments every cycle.
- **LFSR.** 16-bit Fibonacci, taps 16,14,13,11. Steps every cycle in SHUFFLE only. Random index `r` = `lfsr[IDX_W-1:0]`.
- **IDLE priority:** `i_shuffle` > `i_draw_valid` > `i_put_valid`. Lower-priority requests in the same cycle are dropped.
- **Put.** Writes the target pile at index count and increments count, in the same cycle. If the target count == `DEPTH`, the push is dropped and `o_overflow` pulses.
- **Shuffle accept.**
  - `lfsr <= free_cnt ^ SEED`; if that result is 0, load 16'h0001 instead.
  - `idx <= draw_cnt-1`.
  - Go to SHUFFLE.
  - If `draw_cnt` <= 1, SHUFFLE lasts exactly one cycle with no swap.
- **SHUFFLE** (one evaluation per cycle):
  - If `r <= idx`: swap `draw[idx]` and `draw[r]`, then decrement `idx`.
  - Else: retry next cycle with the advanced LFSR.
  - Exit when `idx` reaches 0, or on the first cycle if `draw_cnt` <= 1.
  - On exit: go to DONE if entered from IDLE, or to DRAW if entered from REFILL.
- **Draw accept.** Latch `rem` = clamped count. Go to DRAW.
- **DRAW**, each cycle:
  - If `draw_cnt` > 0: `o_card_valid`=1, `o_card` = top, `draw_cnt--`, `rem--`. When `rem` becomes 0, go to DONE.
  - Else if `disc_cnt` > 0: go to REFILL.
  - Else: set the short flag and go to DONE.
- **REFILL.** Moves one card per cycle: `disc[disc_cnt-1]` → `draw[draw_cnt]`. Both counts update. When `disc_cnt` reaches 0, enter SHUFFLE over the whole draw pile; the LFSR is not reseeded.
- **DONE.** Lasts one cycle: `o_done`=1 and `o_short` = short flag. Clear the short flag, then go to IDLE.
- **Async reset** in any state returns to reset values immediately. A partially completed shuffle or draw is abandoned and pile contents are cleared.

## Timing
- Put accepted at edge k: count visible at k+1.
- Draw of N cards accepted at edge k, draw pile holding >= N:
  - `o_card_valid` in cycles k+1..k+N, top-first order.
  - `o_done` at k+N+1.
  - `o_ready` at k+N+2.
- Draw with refill adds:
  - M REFILL cycles, where M = discard count;
  - plus the SHUFFLE cycles;
  - plus one DRAW cycle that finds the pile empty.
- Shuffle of n >= 2 cards: at least n-1 SHUFFLE cycles (one swap each, plus retry cycles), then 1 DONE cycle.
- `o_ready` is low in every state except IDLE. Inputs presented while `o_ready` is low are ignored with no error.

## Test plan
- **Reset:** assert `i_rst_n`=0 mid-run → on release, `o_ready`=1, both counts 0, `o_card`=0, no strobes.
- **Draw order:** put 0x01,0x02,0x03 to draw pile, draw 2 → `o_card` 0x03 then 0x02 on consecutive cycles, `o_done` next cycle with `o_short`=0, `o_draw_cnt`=1.
- **Shuffle:** load 108 distinct codes, shuffle → `o_done` once, `o_draw_cnt`=108, multiset unchanged, order differs from load order.
- **Refill:** draw pile holds 1 card, discard holds 5, draw 4 → first card, then 5 REFILL cycles, then shuffle, then 3 more cards; `o_draw_cnt`=2, `o_disc_cnt`=0, `o_short`=0.
- **Short draw:** both piles empty, draw 2 → no `o_card_valid`, `o_done`=1 with `o_short`=1 two cycles after accept.
- **Overflow/priority:** discard holds `DEPTH` cards, push to discard → `o_overflow` pulse, count unchanged. Then `i_shuffle` and `i_draw_valid` asserted together → shuffle executes, draw dropped.

Source files
------------

// File: rtl/uno_card_pile_if.sv
// Bundle of request/response signals between the game-control FSM and the card-pile manager.
interface uno_card_pile_if #(
    parameter int CARD_W = 6,
    parameter int CNT_W  = 8
);
    logic              i_put_valid;
    logic              i_put_dst;
    logic [CARD_W-1:0] i_put_card;
    logic              i_shuffle;
    logic              i_draw_valid;
    logic [2:0]        i_draw_cnt;
    logic              o_ready;
    logic              o_card_valid;
    logic [CARD_W-1:0] o_card;
    logic              o_done;
    logic              o_short;
    logic              o_overflow;
    logic [CNT_W-1:0]  o_draw_cnt;
    logic [CNT_W-1:0]  o_disc_cnt;

    modport master (
        output i_put_valid, i_put_dst, i_put_card, i_shuffle, i_draw_valid, i_draw_cnt,
        input  o_ready, o_card_valid, o_card, o_done, o_short, o_overflow, o_draw_cnt, o_disc_cnt
    );

    modport slave (
        input  i_put_valid, i_put_dst, i_put_card, i_shuffle, i_draw_valid, i_draw_cnt,
        output o_ready, o_card_valid, o_card, o_done, o_short, o_overflow, o_draw_cnt, o_disc_cnt
    );
endinterface

// File: rtl/uno_card_pile.sv
// Draw/discard pile manager: pushes, LFSR Fisher-Yates shuffle, multi-card draws with
// automatic refill-and-reshuffle from the discard pile when the draw pile runs dry.
module uno_card_pile #(
    parameter int          CARD_W   = 6,
    parameter int          DEPTH    = 108,
    parameter int          IDX_W    = 7,
    parameter int          CNT_W    = 8,
    parameter int          MAX_DRAW = 4,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input logic           i_clk,
    input logic           i_rst_n,
    uno_card_pile_if.slave pile
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [2:0]       MAX_D    = 3'(MAX_DRAW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHUFFLE,
        S_DRAW,
        S_REFILL,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CARD_W-1:0] draw_mem [DEPTH];
    logic [CARD_W-1:0] disc_mem [DEPTH];
    logic [CNT_W-1:0]  draw_cnt, disc_cnt;
    logic [15:0]       lfsr, free_cnt;
    logic [IDX_W-1:0]  idx;
    logic [2:0]        rem;
    logic              short_flag, from_refill, overflow_q;
    logic [CARD_W-1:0] card_q;

    logic [IDX_W-1:0]  draw_wr, disc_wr, draw_top, disc_top, r;
    logic [15:0]       lfsr_step, seed_val;
    logic [2:0]        draw_req;
    logic              acc_shuffle, acc_draw, acc_put, put_full;
    logic              draw_take, shuf_swap, shuf_exit, refill_move;
    logic              ready, card_valid, done, short_out;

    assign draw_wr   = draw_cnt[IDX_W-1:0];
    assign disc_wr   = disc_cnt[IDX_W-1:0];
    assign draw_top  = draw_wr - IDX_ONE;
    assign disc_top  = disc_wr - IDX_ONE;
    assign r         = lfsr[IDX_W-1:0];
    assign lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign seed_val  = free_cnt ^ SEED;
    assign draw_req  = (pile.i_draw_cnt == 3'd0)  ? 3'd1  :
                       (pile.i_draw_cnt > MAX_D)  ? MAX_D : pile.i_draw_cnt;

    // State register; reset abandons any operation in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode, request acceptance and the externally visible strobes.
    always_comb begin
        state_nxt   = state;
        acc_shuffle = 1'b0;
        acc_draw    = 1'b0;
        acc_put     = 1'b0;
        draw_take   = 1'b0;
        shuf_swap   = 1'b0;
        shuf_exit   = 1'b0;
        refill_move = 1'b0;
        ready       = 1'b0;
        card_valid  = 1'b0;
        done        = 1'b0;
        short_out   = 1'b0;
        put_full    = pile.i_put_dst ? (disc_cnt == FULL_CNT) : (draw_cnt == FULL_CNT);
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (pile.i_shuffle) begin
                    acc_shuffle = 1'b1;
                    state_nxt   = S_SHUFFLE;
                end else if (pile.i_draw_valid) begin
                    acc_draw  = 1'b1;
                    state_nxt = S_DRAW;
                end else if (pile.i_put_valid) begin
                    acc_put = 1'b1;
                end
            end
            S_SHUFFLE: begin
                if (draw_cnt <= CNT_ONE) begin
                    shuf_exit = 1'b1;
                end else if (r <= idx) begin
                    shuf_swap = 1'b1;
                    shuf_exit = (idx == IDX_ONE);
                end
                if (shuf_exit) state_nxt = from_refill ? S_DRAW : S_DONE;
            end
            S_DRAW: begin
                if (draw_cnt != '0) begin
                    draw_take  = 1'b1;
                    card_valid = 1'b1;
                    if (rem == 3'd1) state_nxt = S_DONE;
                end else if (disc_cnt != '0) begin
                    state_nxt = S_REFILL;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_REFILL: begin
                refill_move = (disc_cnt != '0);
                if (disc_cnt <= CNT_ONE) state_nxt = S_SHUFFLE;
            end
            S_DONE: begin
                done      = 1'b1;
                short_out = short_flag;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        pile.o_ready      = ready;
        pile.o_card_valid = card_valid;
        pile.o_card       = card_valid ? draw_mem[draw_top] : card_q;
        pile.o_done       = done;
        pile.o_short      = short_out;
        pile.o_overflow   = overflow_q;
        pile.o_draw_cnt   = draw_cnt;
        pile.o_disc_cnt   = disc_cnt;
    end

    // Pile storage, counts, shuffle index/LFSR and draw bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                draw_mem[i] <= '0;
                disc_mem[i] <= '0;
            end
            draw_cnt    <= '0;
            disc_cnt    <= '0;
            lfsr        <= 16'h0001;
            free_cnt    <= '0;
            idx         <= '0;
            rem         <= '0;
            short_flag  <= 1'b0;
            from_refill <= 1'b0;
            overflow_q  <= 1'b0;
            card_q      <= '0;
        end else begin
            free_cnt   <= free_cnt + 16'd1;
            overflow_q <= acc_put & put_full;
            if (acc_put && !put_full) begin
                if (pile.i_put_dst) begin
                    disc_mem[disc_wr] <= pile.i_put_card;
                    disc_cnt          <= disc_cnt + CNT_ONE;
                end else begin
                    draw_mem[draw_wr] <= pile.i_put_card;
                    draw_cnt          <= draw_cnt + CNT_ONE;
                end
            end
            if (acc_shuffle) begin
                lfsr        <= (seed_val == 16'h0000) ? 16'h0001 : seed_val;
                idx         <= draw_top;
                from_refill <= 1'b0;
            end
            if (acc_draw) rem <= draw_req;
            if (state == S_SHUFFLE) lfsr <= lfsr_step;
            if (shuf_swap) begin
                draw_mem[idx] <= draw_mem[r];
                draw_mem[r]   <= draw_mem[idx];
                idx           <= idx - IDX_ONE;
            end
            if (draw_take) begin
                card_q   <= draw_mem[draw_top];
                draw_cnt <= draw_cnt - CNT_ONE;
                rem      <= rem - 3'd1;
            end
            if (state == S_DRAW && draw_cnt == '0 && disc_cnt == '0) short_flag <= 1'b1;
            if (refill_move) begin
                draw_mem[draw_wr] <= disc_mem[disc_top];
                draw_cnt          <= draw_cnt + CNT_ONE;
                disc_cnt          <= disc_cnt - CNT_ONE;
                if (disc_cnt == CNT_ONE) begin
                    idx         <= draw_wr;
                    from_refill <= 1'b1;
                end
            end
            if (state == S_DONE) short_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uno_card_pile.sv
// Randomised scoreboard bench for uno_card_pile against a queue-based model of the two piles.
module tb_uno_card_pile;

    localparam int CARD_W = 6;
    localparam int CNT_W  = 8;
    localparam int DEPTH  = 108;
    localparam int K_CARD = 0;
    localparam int K_DONE = 1;
    localparam int K_OVF  = 2;

    typedef struct {
        int kind;
        int card;
        bit shrt;
        int dcnt;
        int xcnt;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uno_card_pile_if #(.CARD_W(CARD_W), .CNT_W(CNT_W)) pile ();

    uno_card_pile #(
        .CARD_W(CARD_W), .DEPTH(DEPTH), .IDX_W(7), .CNT_W(CNT_W),
        .MAX_DRAW(4), .SEED(16'hACE1)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .pile   (pile)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t exp_q[$];
    int   m_draw[$];
    int   m_disc[$];
    int   any_pool[$];
    int   drawn_log[$];
    int   load_list[$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic push_exp(input int kind, input int card, input bit shrt);
        exp_t e;
        e.kind = kind;
        e.card = card;
        e.shrt = shrt;
        e.dcnt = m_draw.size();
        e.xcnt = m_disc.size();
        exp_q.push_back(e);
    endtask

    task automatic model_put(input bit dst, input int card);
        if (dst) begin
            if (m_disc.size() == DEPTH) push_exp(K_OVF, -1, 1'b0);
            else m_disc.push_back(card);
        end else begin
            if (m_draw.size() == DEPTH) push_exp(K_OVF, -1, 1'b0);
            else m_draw.push_back(card);
        end
    endtask

    task automatic model_shuffle(output int lat);
        lat = (m_draw.size() <= 1) ? 2 : -1;
        foreach (m_draw[i]) begin
            if (m_draw[i] >= 0) begin
                any_pool.push_back(m_draw[i]);
                m_draw[i] = -1;
            end
        end
        push_exp(K_DONE, -1, 1'b0);
    endtask

    task automatic model_draw(input int n, output int lat);
        int rem, taken, v;
        bit shrt, refilled;
        rem      = (n == 0) ? 1 : ((n > 4) ? 4 : n);
        taken    = 0;
        shrt     = 1'b0;
        refilled = 1'b0;
        while (rem > 0) begin
            if (m_draw.size() > 0) begin
                v = m_draw.pop_back();
                push_exp(K_CARD, v, 1'b0);
                rem--;
                taken++;
            end else if (m_disc.size() > 0) begin
                while (m_disc.size() > 0) begin
                    any_pool.push_back(m_disc.pop_back());
                    m_draw.push_back(-1);
                end
                refilled = 1'b1;
            end else begin
                shrt = 1'b1;
                break;
            end
        end
        push_exp(K_DONE, -1, shrt);
        lat = refilled ? -1 : (taken + int'(shrt) + 1);
    endtask

    task automatic idle_inputs();
        pile.i_put_valid  = 1'b0;
        pile.i_put_dst    = 1'b0;
        pile.i_put_card   = '0;
        pile.i_shuffle    = 1'b0;
        pile.i_draw_valid = 1'b0;
        pile.i_draw_cnt   = '0;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!pile.o_ready && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!pile.o_ready) checkOutput("ready_timeout", int'(pile.o_ready), 1);
    endtask

    task automatic applyStimulus(input bit sh, input bit dv, input bit pv, input bit dst,
                                 input int card, input int cnt);
        int lat, cyc;
        lat = -1;
        if (sh) model_shuffle(lat);
        else if (dv) model_draw(cnt, lat);
        else if (pv) model_put(dst, card);
        pile.i_shuffle    = sh;
        pile.i_draw_valid = dv;
        pile.i_put_valid  = pv;
        pile.i_put_dst    = dst;
        pile.i_put_card   = CARD_W'(card);
        pile.i_draw_cnt   = 3'(cnt);
        @(posedge clk);
        #1;
        idle_inputs();
        wait_ready(cyc);
        if ((sh || dv) && lat >= 0) checkOutput("op_latency", cyc, lat);
        if (pv && !sh && !dv) begin
            checkOutput("put_draw_cnt", int'(pile.o_draw_cnt), m_draw.size());
            checkOutput("put_disc_cnt", int'(pile.o_disc_cnt), m_disc.size());
        end
    endtask

    task automatic check_reset_state();
        checkOutput("rst_ready", int'(pile.o_ready), 1);
        checkOutput("rst_draw_cnt", int'(pile.o_draw_cnt), 0);
        checkOutput("rst_disc_cnt", int'(pile.o_disc_cnt), 0);
        checkOutput("rst_card", int'(pile.o_card), 0);
        checkOutput("rst_card_valid", int'(pile.o_card_valid), 0);
        checkOutput("rst_done", int'(pile.o_done), 0);
        checkOutput("rst_short", int'(pile.o_short), 0);
        checkOutput("rst_overflow", int'(pile.o_overflow), 0);
    endtask

    task automatic drain_all();
        int guard;
        guard = 0;
        while ((m_draw.size() + m_disc.size()) > 0 && guard < 200) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 4);
            guard++;
        end
    endtask

    exp_t mon_e;
    int   mon_hits[$];

    // Monitor: pops the scoreboard whenever the DUT presents a card, done or overflow.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pile.o_card_valid) begin
                drawn_log.push_back(int'(pile.o_card));
                checkOutput("card_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    checkOutput("card_event_kind", K_CARD, mon_e.kind);
                    if (mon_e.kind == K_CARD) begin
                        if (mon_e.card >= 0) begin
                            checkOutput("card_value", int'(pile.o_card), mon_e.card);
                        end else begin
                            mon_hits = any_pool.find_first_index(x) with (x == int'(pile.o_card));
                            checkOutput("card_in_shuffled_pool", mon_hits.size(), 1);
                            if (mon_hits.size() > 0) any_pool.delete(mon_hits[0]);
                        end
                    end
                end
            end
            if (pile.o_done) begin
                checkOutput("done_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    checkOutput("done_event_kind", K_DONE, mon_e.kind);
                    checkOutput("done_short", int'(pile.o_short), int'(mon_e.shrt));
                    checkOutput("done_draw_cnt", int'(pile.o_draw_cnt), mon_e.dcnt);
                    checkOutput("done_disc_cnt", int'(pile.o_disc_cnt), mon_e.xcnt);
                end
            end
            if (pile.o_overflow) begin
                checkOutput("overflow_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    checkOutput("overflow_event_kind", K_OVF, mon_e.kind);
                end
            end
        end
    end

    // Directed scenarios, then randomised traffic, then a reset in mid-draw.
    initial begin
        int lat, same, op;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_state();

        // Top-first draw order and exact latency.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 2);

        // Count 0 draws one card; then a draw with both piles empty ends short.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

        // Counts above MAX_DRAW clamp to 4.
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 10 + i, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 7);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 2);

        // Refill mid-draw from the discard pile.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h30, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h20 + i, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 4);
        drain_all();

        // Full-pile shuffle: multiset preserved, order changed.
        load_list.delete();
        for (int i = 0; i < DEPTH; i++) begin
            load_list.push_back((i * 37 + 5) % 64);
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, (i * 37 + 5) % 64, 0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        drawn_log.delete();
        drain_all();
        checkOutput("shuffle_drawn_total", drawn_log.size(), DEPTH);
        same = 1;
        foreach (drawn_log[i]) if (i < DEPTH && drawn_log[i] != load_list[DEPTH - 1 - i]) same = 0;
        checkOutput("shuffle_order_changed", same, 0);

        // Overflow on a full discard pile, then request priority.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, $urandom_range(0, 63), 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h3F, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, $urandom_range(0, 63), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 2);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h12, 1);

        // Randomised mix of puts, draws, shuffles and simultaneous requests.
        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: applyStimulus(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 63), 0);
                3:       applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, $urandom_range(0, 63), 0);
                4, 5, 6: applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, $urandom_range(0, 7));
                7:       applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
                default: applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                       $urandom_range(0, 63), $urandom_range(0, 7));
            endcase
        end

        // Reset asserted while a draw is in progress.
        drain_all();
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 40 + i, 0);
        model_draw(4, lat);
        pile.i_draw_valid = 1'b1;
        pile.i_draw_cnt   = 3'd4;
        @(posedge clk);
        #1;
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        m_draw.delete();
        m_disc.delete();
        any_pool.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_state();

        // Block operates normally after the reset.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h2A, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 1);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_leftover", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
